// File: rtl/ps2_key_event_scanner.sv
// PS/2 scan-code set 2 decoder: tracks a small set of watched keys as a held-key bitmap
// and queues make/break events in a first-word-fall-through FIFO.
module ps2_key_event_scanner #(
  parameter int unsigned               NUM_KEYS        = 5,
  parameter int unsigned               IDX_W           = 3,
  // Slot 0 in the LSBs: up, down, left, right, enter.
  parameter logic [NUM_KEYS*9-1:0]     KEY_CODES       = {9'h05A, 9'h174, 9'h16B, 9'h172, 9'h175},
  parameter int unsigned               FIFO_DEPTH      = 8,
  parameter int unsigned               CNT_W           = 4,
  parameter bit                        SUPPRESS_REPEAT = 1'b1,
  parameter int unsigned               TIMEOUT         = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic                ev_break,
  output logic [IDX_W-1:0]    ev_index,
  output logic [CNT_W-1:0]    ev_count,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StGotE0, StGotF0, StGotE0F0} state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                hit_q, hit_d, brk_q, brk_d, clr_q, clr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic [IDX_W:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;

  logic res_valid, res_ext, match, push, pop, full, do_push, drop;

  // Stage 1: prefix parser, timeout and key lookup.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_valid = 1'b0;
    res_ext   = 1'b0;
    brk_d     = 1'b0;
    clr_d     = 1'b0;
    if (byte_valid) begin
      cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (byte_data == 8'hE0)      state_d = StGotE0;
          else if (byte_data == 8'hF0) state_d = StGotF0;
          else if (byte_data == 8'hAA) clr_d = 1'b1;
          else if (byte_data != 8'hE1) res_valid = 1'b1;
        end
        StGotE0: begin
          if (byte_data == 8'hF0) state_d = StGotE0F0;
          else if (byte_data != 8'hE0) begin
            res_valid = 1'b1;
            res_ext   = 1'b1;
            state_d   = StIdle;
          end
        end
        StGotF0: begin
          res_valid = 1'b1;
          brk_d     = 1'b1;
          state_d   = StIdle;
        end
        default: begin
          res_valid = 1'b1;
          res_ext   = 1'b1;
          brk_d     = 1'b1;
          state_d   = StIdle;
        end
      endcase
    end else if (state_q != StIdle) begin
      if (cnt_q == TW'(TIMEOUT - 1)) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Descending scan so the lowest matching slot wins.
    match = 1'b0;
    idx_d = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if ({res_ext, byte_data} == KEY_CODES[9*i +: 9]) begin
        match = 1'b1;
        idx_d = IDX_W'(i);
      end
    end
    hit_d = res_valid && match;
  end

  // Stage 2: apply to the bitmap and push the event.
  always_comb begin
    key_down_d = key_down_q;
    push       = 1'b0;
    if (clr_q) begin
      key_down_d = '0;
    end else if (hit_q) begin
      if (!brk_q) begin
        if (!key_down_q[idx_q]) begin
          key_down_d[idx_q] = 1'b1;
          push              = 1'b1;
        end else if (!SUPPRESS_REPEAT) begin
          push = 1'b1;
        end
      end else if (key_down_q[idx_q]) begin
        key_down_d[idx_q] = 1'b0;
        push              = 1'b1;
      end
    end

    pop      = (count_q != '0) && ev_ready;
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    do_push  = push && (!full || pop);
    drop     = push && full && !pop;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;
    overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      brk_q      <= 1'b0;
      clr_q      <= 1'b0;
      idx_q      <= '0;
      key_down_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      brk_q      <= brk_d;
      clr_q      <= clr_d;
      idx_q      <= idx_d;
      key_down_q <= key_down_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {brk_q, idx_q};
  end

  assign key_down = key_down_q;
  assign ev_valid = (count_q != '0);
  assign ev_break = ev_valid & mem_q[rd_ptr_q][IDX_W];
  assign ev_index = ev_valid ? mem_q[rd_ptr_q][IDX_W-1:0] : '0;
  assign ev_count = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_scanner.sv
// Bench for ps2_key_event_scanner: scoreboard of expected events on the main instance,
// plus a no-repeat-suppression instance and a depth-4 instance for their specific cases.
module tb_ps2_key_event_scanner;

  localparam int unsigned T = 20;

  logic       clk = 1'b0;
  logic       rst, byte_valid, ev_ready, clr_overflow;
  logic [7:0] byte_data;

  logic [4:0] kd_m, kd_n, kd_s;
  logic       v_m, v_n, v_s, b_m, b_n, b_s, o_m, o_n, o_s;
  logic [2:0] i_m, i_n, i_s;
  logic [3:0] c_m, c_n;
  logic [2:0] c_s;

  logic [3:0] exp_q[$];
  logic [3:0] exp_e;
  int         n_err = 0;
  int         n_chk = 0;

  always #5 clk = ~clk;

  ps2_key_event_scanner #(.TIMEOUT(T)) u_main (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .key_down(kd_m), .ev_valid(v_m), .ev_ready(ev_ready), .ev_break(b_m),
    .ev_index(i_m), .ev_count(c_m), .overflow(o_m), .clr_overflow(clr_overflow)
  );

  ps2_key_event_scanner #(.TIMEOUT(T), .SUPPRESS_REPEAT(1'b0)) u_norep (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .key_down(kd_n), .ev_valid(v_n), .ev_ready(ev_ready), .ev_break(b_n),
    .ev_index(i_n), .ev_count(c_n), .overflow(o_n), .clr_overflow(clr_overflow)
  );

  ps2_key_event_scanner #(.TIMEOUT(T), .FIFO_DEPTH(4), .CNT_W(3)) u_small (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .key_down(kd_s), .ev_valid(v_s), .ev_ready(ev_ready), .ev_break(b_s),
    .ev_index(i_s), .ev_count(c_s), .overflow(o_s), .clr_overflow(clr_overflow)
  );

  // Scoreboard: every head the main instance hands over is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && v_m && ev_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL ev_unexpected: got brk=%0b idx=%0d, none expected", b_m, i_m);
      end else begin
        exp_e = exp_q.pop_front();
        if ({b_m, i_m} !== exp_e) begin
          n_err++;
          $display("FAIL ev_head: got brk=%0b idx=%0d want brk=%0b idx=%0d",
                   b_m, i_m, exp_e[3], exp_e[2:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic brk, input logic [2:0] idx);
    exp_q.push_back({brk, idx});
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int k = 0;
    ev_ready = 1'b1;
    while ((exp_q.size() != 0 || v_m) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    n_chk++;
    if (exp_q.size() != 0 || v_m) begin
      n_err++;
      $display("FAIL %s_drain: got %0d events still expected, ev_valid=%0b, want 0 and 0",
               name, exp_q.size(), v_m);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    n_chk++;
    if ({kd_m, v_m, b_m, i_m, c_m, o_m} !== 15'd0) begin
      n_err++; $display("FAIL reset_main: got %h want 0", {kd_m, v_m, b_m, i_m, c_m, o_m});
    end
    n_chk++;
    if ({kd_n, v_n, b_n, i_n, c_n, o_n} !== 15'd0) begin
      n_err++; $display("FAIL reset_norep: got %h want 0", {kd_n, v_n, b_n, i_n, c_n, o_n});
    end
    n_chk++;
    if ({kd_s, v_s, b_s, i_s, c_s, o_s} !== 14'd0) begin
      n_err++; $display("FAIL reset_small: got %h want 0", {kd_s, v_s, b_s, i_s, c_s, o_s});
    end
  endtask

  task automatic test_ext_keys();
    reset_dut();
    ev_ready = 1'b0;
    send(8'hE0); send(8'h75); expect_ev(1'b0, 3'd0);
    settle();
    n_chk++;
    if (kd_m !== 5'b00001) begin
      n_err++; $display("FAIL ext_make_keys: got %b want 00001", kd_m);
    end
    n_chk++;
    if (v_m !== 1'b1) begin
      n_err++; $display("FAIL ext_make_valid: got %b want 1", v_m);
    end
    send(8'hE0); send(8'hF0); send(8'h75); expect_ev(1'b1, 3'd0);
    settle();
    n_chk++;
    if (kd_m !== 5'b00000) begin
      n_err++; $display("FAIL ext_break_keys: got %b want 00000", kd_m);
    end
    n_chk++;
    if (c_m !== 4'd2) begin
      n_err++; $display("FAIL ext_count: got %0d want 2", c_m);
    end
    drain("ext");
  endtask

  task automatic test_non_ext();
    reset_dut();
    send(8'h75);
    settle();
    n_chk++;
    if ({kd_m, c_m} !== 9'd0) begin
      n_err++; $display("FAIL kp8_ignored: got keys=%b count=%0d want 0 and 0", kd_m, c_m);
    end
    send(8'h5A); expect_ev(1'b0, 3'd4);
    settle();
    n_chk++;
    if (kd_m !== 5'b10000) begin
      n_err++; $display("FAIL enter_keys: got %b want 10000", kd_m);
    end
    drain("non_ext");
  endtask

  task automatic test_repeat();
    reset_dut();
    ev_ready = 1'b0;
    send(8'h5A); send(8'h5A); send(8'h5A); expect_ev(1'b0, 3'd4);
    settle();
    n_chk++;
    if (c_m !== 4'd1) begin
      n_err++; $display("FAIL repeat_suppressed: got %0d events want 1", c_m);
    end
    n_chk++;
    if (c_n !== 4'd3) begin
      n_err++; $display("FAIL repeat_kept: got %0d events want 3", c_n);
    end
    n_chk++;
    if ({v_n, b_n, i_n} !== 5'b1_0_100) begin
      n_err++; $display("FAIL repeat_head: got %b want 10100", {v_n, b_n, i_n});
    end
    drain("repeat");
    idle(3);
    n_chk++;
    if ({c_n, kd_n} !== {4'd0, 5'b10000}) begin
      n_err++; $display("FAIL repeat_norep_end: got count=%0d keys=%b want 0 and 10000", c_n, kd_n);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] hd[4];
    hd = '{4'h0, 4'h1, 4'h2, 4'h8};
    reset_dut();
    ev_ready = 1'b0;
    send(8'hE0); send(8'h75); expect_ev(1'b0, 3'd0);
    send(8'hE0); send(8'h72); expect_ev(1'b0, 3'd1);
    send(8'hE0); send(8'h6B); expect_ev(1'b0, 3'd2);
    send(8'hE0); send(8'hF0); send(8'h75); expect_ev(1'b1, 3'd0);
    send(8'hE0); send(8'hF0); send(8'h72); expect_ev(1'b1, 3'd1);
    send(8'hE0); send(8'hF0); send(8'h6B); expect_ev(1'b1, 3'd2);
    settle();
    n_chk++;
    if ({c_s, o_s, kd_s} !== {3'd4, 1'b1, 5'd0}) begin
      n_err++; $display("FAIL ovf_small: got count=%0d ovf=%b keys=%b want 4 1 00000", c_s, o_s, kd_s);
    end
    n_chk++;
    if ({c_m, o_m} !== {4'd6, 1'b0}) begin
      n_err++; $display("FAIL ovf_main: got count=%0d ovf=%b want 6 0", c_m, o_m);
    end
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    n_chk++;
    if (o_s !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: got %b want 0", o_s);
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({v_s, b_s, i_s} !== {1'b1, hd[i]}) begin
        n_err++; $display("FAIL ovf_head%0d: got %b want %b", i, {v_s, b_s, i_s}, {1'b1, hd[i]});
      end
      @(posedge clk); #1;
    end
    drain("ovf");
  endtask

  task automatic test_timeout();
    reset_dut();
    send(8'hE0); idle(T); send(8'h75);
    settle();
    n_chk++;
    if ({kd_m, c_m} !== 9'd0) begin
      n_err++; $display("FAIL timeout_drop: got keys=%b count=%0d want 0 and 0", kd_m, c_m);
    end
    send(8'hE0); idle(T - 1); send(8'h75); expect_ev(1'b0, 3'd0);
    settle();
    n_chk++;
    if (kd_m !== 5'b00001) begin
      n_err++; $display("FAIL timeout_keep: got %b want 00001", kd_m);
    end
    drain("timeout");
  endtask

  task automatic test_clear_all();
    reset_dut();
    ev_ready = 1'b0;
    send(8'hE0); send(8'h75); expect_ev(1'b0, 3'd0);
    send(8'h5A); expect_ev(1'b0, 3'd4);
    settle();
    n_chk++;
    if (kd_m !== 5'b10001) begin
      n_err++; $display("FAIL clr_before: got %b want 10001", kd_m);
    end
    send(8'hAA);
    settle();
    n_chk++;
    if ({kd_m, c_m} !== {5'd0, 4'd2}) begin
      n_err++; $display("FAIL clr_after: got keys=%b count=%0d want 00000 2", kd_m, c_m);
    end
    drain("clr");
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ev_ready = 1'b0;
    send(8'h5A);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    settle();
    n_chk++;
    if ({kd_m, c_m} !== 9'd0) begin
      n_err++; $display("FAIL rst_inflight: got keys=%b count=%0d want 0 and 0", kd_m, c_m);
    end
    send(8'hE0); send(8'hF0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'h75);
    settle();
    n_chk++;
    if ({kd_m, v_m, b_m, i_m, c_m, o_m} !== 15'd0) begin
      n_err++; $display("FAIL rst_prefix: got %h want 0", {kd_m, v_m, b_m, i_m, c_m, o_m});
    end
    drain("rst_mid");
  endtask

  task automatic test_back_to_back();
    reset_dut();
    ev_ready = 1'b1;
    send(8'hE0); send(8'h75); expect_ev(1'b0, 3'd0);
    send(8'h5A); expect_ev(1'b0, 3'd4);
    send(8'h5A);
    send(8'hF0); send(8'h5A); expect_ev(1'b1, 3'd4);
    send(8'hE0); send(8'hF0); send(8'h75); expect_ev(1'b1, 3'd0);
    settle();
    drain("b2b");
    n_chk++;
    if (kd_m !== 5'd0) begin
      n_err++; $display("FAIL b2b_keys: got %b want 00000", kd_m);
    end
  endtask

  initial begin
    rst          = 1'b1;
    byte_valid   = 1'b0;
    byte_data    = 8'h00;
    ev_ready     = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ext_keys();
    test_non_ext();
    test_repeat();
    test_overflow();
    test_timeout();
    test_clear_all();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
